// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with a register file, a read-only ID word, wait states and saturating transfer counters.
module apb_slave_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 16'hA5B1
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic [7:0]            wr_count,
  output logic [7:0]            rd_count
);
  localparam int TOP = 2**ADDR_WIDTH - 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [2:0] {IDLE = 3'b001, ACCESS = 3'b010, DONE = 3'b100} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [DATA_WIDTH-1:0] mem [TOP];
  logic fin, id_hit;
  always_comb begin
    fin = state == ACCESS && psel && penable && cnt == 4'd0;
    id_hit = paddr == ADDR_WIDTH'(TOP);
    next = state == IDLE   ? (psel && !penable ? ACCESS : IDLE) :
           state == ACCESS ? (!psel ? IDLE : fin ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= IDLE;
      cnt <= 4'd0;
      pready <= 1'b0;
      prdata <= '0;
      wr_count <= 8'd0;
      rd_count <= 8'd0;
      for (int i = 0; i < TOP; i++) mem[i] <= '0;
    end else begin
      state <= next;
      pready <= fin;
      if (state == IDLE && psel && !penable) cnt <= WS;
      else if (state == ACCESS && psel && penable && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (fin && pwrite) begin
        if (!id_hit) mem[paddr] <= pwdata;
        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      end
      if (fin && !pwrite) begin
        prdata <= id_hit ? ID_VALUE : mem[paddr];
        if (rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed vectors against a zero-wait and a three-wait instance of apb_slave_mem.
module tb_apb_slave_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic prst [2], psel [2], penable [2], pwrite [2], pready [2];
  logic [3:0] paddr [2];
  logic [15:0] pwdata [2], prdata [2];
  logic [7:0] wr_count [2], rd_count [2];
  int n_cmp = 0, n_bad = 0, pulses = 0, p0;
  apb_slave_mem #(.WAIT_STATES(0)) u0 (
    .pclk(clk), .prst(prst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .wr_count(wr_count[0]), .rd_count(rd_count[0]));
  apb_slave_mem #(.WAIT_STATES(3)) u1 (
    .pclk(clk), .prst(prst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .wr_count(wr_count[1]), .rd_count(rd_count[1]));
  always @(posedge clk) if (pready[0]) pulses <= pulses + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Behaves like the master: setup, enable until pready, stale select through the DONE cycle.
  task automatic xfer(input int u, input bit wr, input logic [3:0] a, input logic [15:0] d);
    int lat = 0;
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
    @(posedge clk); #1 penable[u] = 1'b1;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (pready[u]) lat = n;
    end
    chk($sformatf("latency u%0d", u), lat, u == 0 ? 1 : 4);
    @(posedge clk); #1;
    chk($sformatf("pready_one_cycle u%0d", u), {31'd0, pready[u]}, 0);
    psel[u] = 1'b0; penable[u] = 1'b0;
  endtask
  typedef struct {
    bit wr;
    logic [3:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic [7:0] exp_wc, exp_rc;
  } vec_t;
  vec_t v [8];
  initial begin
    v[0] = '{1, 4'h3, 16'h1234, 16'h0000, 8'd1, 8'd0};
    v[1] = '{0, 4'h3, 16'h0000, 16'h1234, 8'd1, 8'd1};
    v[2] = '{1, 4'hF, 16'h0000, 16'h1234, 8'd2, 8'd1};
    v[3] = '{0, 4'hF, 16'h0000, 16'hA5B1, 8'd2, 8'd2};
    v[4] = '{0, 4'h0, 16'h0000, 16'h0000, 8'd2, 8'd3};
    v[5] = '{1, 4'hE, 16'hABCD, 16'h0000, 8'd3, 8'd3};
    v[6] = '{0, 4'hE, 16'h0000, 16'hABCD, 8'd3, 8'd4};
    v[7] = '{0, 4'h3, 16'h0000, 16'h1234, 8'd3, 8'd5};
    for (int u = 0; u < 2; u++) begin
      prst[u] = 1'b1; psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
      paddr[u] = 4'h0; pwdata[u] = 16'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset pready", {31'd0, pready[0]}, 0);
    chk("reset prdata", {16'd0, prdata[0]}, 0);
    chk("reset wr_count", {24'd0, wr_count[0]}, 0);
    chk("reset rd_count", {24'd0, rd_count[0]}, 0);
    prst[0] = 1'b0; prst[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xfer(0, v[i].wr, v[i].addr, v[i].data);
      chk($sformatf("vec%0d prdata", i), {16'd0, prdata[0]}, {16'd0, v[i].exp_rd});
      chk($sformatf("vec%0d wr_count", i), {24'd0, wr_count[0]}, {24'd0, v[i].exp_wc});
      chk($sformatf("vec%0d rd_count", i), {24'd0, rd_count[0]}, {24'd0, v[i].exp_rc});
    end
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 4'h2; pwdata[0] = 16'hFFFF;
    @(posedge clk); #1 psel[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort pready", {31'd0, pready[0]}, 0);
    end
    chk("abort wr_count", {24'd0, wr_count[0]}, 3);
    xfer(0, 0, 4'h2, 16'h0);
    chk("abort mem2", {16'd0, prdata[0]}, 0);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 4'h4;
    repeat (4) begin
      @(posedge clk); #1;
      chk("stale pready", {31'd0, pready[0]}, 0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("stale rd_count", {24'd0, rd_count[0]}, 6);
    p0 = pulses;
    for (int i = 0; i < 260; i++) xfer(0, 1, 4'h7, 16'(i));
    chk("sat pulses", pulses - p0, 260);
    chk("sat wr_count", {24'd0, wr_count[0]}, 8'hFF);
    xfer(0, 0, 4'h7, 16'h0);
    chk("sat mem7", {16'd0, prdata[0]}, 16'h0103);
    xfer(1, 1, 4'h5, 16'hBEEF);
    xfer(1, 0, 4'h5, 16'h0);
    chk("ws prdata", {16'd0, prdata[1]}, 16'hBEEF);
    chk("ws counts", {16'd0, wr_count[1], rd_count[1]}, 16'h0101);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 4'h3; pwdata[1] = 16'h5555;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 prst[1] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst pready", {31'd0, pready[1]}, 0);
    end
    chk("rst prdata", {16'd0, prdata[1]}, 0);
    chk("rst counts", {16'd0, wr_count[1], rd_count[1]}, 0);
    prst[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst pready", {31'd0, pready[1]}, 0);
    end
    xfer(1, 0, 4'h3, 16'h0);
    chk("rst mem3", {16'd0, prdata[1]}, 0);
    chk("rst counts after", {16'd0, wr_count[1], rd_count[1]}, 16'h0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
